// File: rtl/seq_ripple_borrow_subtractor.sv
// Multi-cycle unsigned subtractor: resolves SEG_LEN bits per cycle through a ripple borrow chain.
// Optional borrow-in port Bin is enabled by defining SEQ_SUB_BORROW_IN_EN.
module seq_ripple_borrow_subtractor #(
   parameter int unsigned BIT_LEN = 17,
   parameter int unsigned SEG_LEN = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BIT_LEN-1:0] A,
   input  logic [BIT_LEN-1:0] B,
`ifdef SEQ_SUB_BORROW_IN_EN
   input  logic               Bin,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BIT_LEN:0]   D
);

   localparam int unsigned NSEG  = (BIT_LEN + SEG_LEN - 1) / SEG_LEN;
   localparam int unsigned CNT_W = $clog2(NSEG + 1);
   localparam int unsigned IDX_W = $clog2(BIT_LEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [BIT_LEN-1:0] a_q, b_q;
   logic [BIT_LEN:0]   d_q, d_next;
   logic [CNT_W-1:0]   cnt_q;
   logic               borrow_q, borrow_next;
   logic               armed_q;
   logic               accept, last_seg, bin_in;

`ifdef SEQ_SUB_BORROW_IN_EN
   assign bin_in = Bin;
`else
   assign bin_in = 1'b0;
`endif

   assign last_seg = (cnt_q == CNT_W'(NSEG - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // armed_q keeps in_ready low until the first edge after reset release
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = armed_q;
            accept   = in_valid & armed_q;
            if (accept) state_d = BUSY;
         end
         BUSY: begin
            if (last_seg) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Ripple borrow across the current segment; bits past BIT_LEN in a partial last segment are skipped
   always_comb begin
      logic [BIT_LEN:0] a_ext, b_ext;
      int unsigned      seg_base, idx;
      logic             br, ai, bi;
      a_ext    = {1'b0, a_q};
      b_ext    = {1'b0, b_q};
      d_next   = d_q;
      br       = borrow_q;
      seg_base = 32'(cnt_q) * SEG_LEN;
      idx      = 0;
      ai       = 1'b0;
      bi       = 1'b0;
      for (int unsigned i = 0; i < SEG_LEN; i++) begin
         idx = seg_base + i;
         if (idx < BIT_LEN) begin
            ai = a_ext[idx[IDX_W-1:0]];
            bi = b_ext[idx[IDX_W-1:0]];
            d_next[idx[IDX_W-1:0]] = ai ^ bi ^ br;
            br = (~ai & bi) | (~(ai ^ bi) & br);
         end
      end
      if (last_seg) d_next[BIT_LEN] = br;
      borrow_next = br;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         armed_q  <= 1'b0;
      end else begin
         armed_q <= 1'b1;
         if (accept) begin
            a_q      <= A;
            b_q      <= B;
            d_q      <= '0;
            borrow_q <= bin_in;
            cnt_q    <= '0;
         end else if (state_q == BUSY) begin
            d_q      <= d_next;
            borrow_q <= borrow_next;
            if (!last_seg) cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign D = d_q;

endmodule

// File: tb/tb_seq_ripple_borrow_subtractor.sv
// Directed table-driven bench for seq_ripple_borrow_subtractor (BIT_LEN=17, SEG_LEN=4, NSEG=5).
// Bin vectors are added when SEQ_SUB_BORROW_IN_EN is defined.
module tb_seq_ripple_borrow_subtractor;

   localparam int BIT_LEN = 17;
   localparam int SEG_LEN = 4;
   localparam int NSEG    = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [BIT_LEN-1:0] A = '0;
   logic [BIT_LEN-1:0] B = '0;
   logic              Bin = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [BIT_LEN:0]  D;

   int checks   = 0;
   int failures = 0;

   seq_ripple_borrow_subtractor #(.BIT_LEN(BIT_LEN), .SEG_LEN(SEG_LEN)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
`ifdef SEQ_SUB_BORROW_IN_EN
      .Bin      (Bin),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .D        (D)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BIT_LEN-1:0] a;
      logic [BIT_LEN-1:0] b;
      logic               bin;
      logic [BIT_LEN:0]   d;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation, scramble A/B and hold in_valid during BUSY, measure latency, check D, then pop it.
   task automatic run_op(input string name, input vec_t v);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check({name, "_ready"}, 32'(in_ready), 32'd1);
      A = v.a; B = v.b; Bin = v.bin; in_valid = 1'b1;
      tick();
      check({name, "_busy_ready"}, 32'(in_ready), 32'd0);
      A = ~v.a; B = ~v.b; Bin = ~v.bin;
      n = 0;
      while (!out_valid && n < NSEG + 4) begin
         tick();
         n++;
      end
      in_valid = 1'b0;
      check({name, "_latency"}, 32'(n), 32'(NSEG));
      check({name, "_d"}, 32'(D), 32'(v.d));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_popped"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      vec_t vecs[$];
      vec_t v;
      int   seen;

      vecs.push_back('{17'h00005, 17'h00003, 1'b0, 18'h00002});
      vecs.push_back('{17'h00003, 17'h00005, 1'b0, 18'h3FFFE});
      vecs.push_back('{17'h1FFFF, 17'h1FFFF, 1'b0, 18'h00000});
      vecs.push_back('{17'h00000, 17'h00001, 1'b0, 18'h3FFFF});
      vecs.push_back('{17'h10000, 17'h00001, 1'b0, 18'h0FFFF});
      vecs.push_back('{17'h0000F, 17'h00010, 1'b0, 18'h3FFFF});
      vecs.push_back('{17'h12345, 17'h02345, 1'b0, 18'h10000});
      vecs.push_back('{17'h00000, 17'h1FFFF, 1'b0, 18'h20001});
      vecs.push_back('{17'h1FFFF, 17'h00000, 1'b0, 18'h1FFFF});
      vecs.push_back('{17'h0F0F0, 17'h00F0F, 1'b0, 18'h0E1E1});
      vecs.push_back('{17'h00100, 17'h10000, 1'b0, 18'h30100});
`ifdef SEQ_SUB_BORROW_IN_EN
      vecs.push_back('{17'h00005, 17'h00003, 1'b1, 18'h00001});
      vecs.push_back('{17'h00000, 17'h00000, 1'b1, 18'h3FFFF});
`endif

      #2;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_d", 32'(D), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("prerelease_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("first_edge_in_ready", 32'(in_ready), 32'd1);

      foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

      // Backpressure: result must hold for 10 cycles while in_valid pulses are ignored
      A = 17'h00007; B = 17'h00002; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      seen = 0;
      while (!out_valid && seen < NSEG + 4) begin
         tick();
         seen++;
      end
      check("hold_latency", 32'(seen), 32'(NSEG));
      for (int c = 0; c < 10; c++) begin
         A = 17'(c * 977); B = 17'(c * 31 + 1); in_valid = c[0];
         tick();
         check($sformatf("hold_valid%0d", c), 32'(out_valid), 32'd1);
         check($sformatf("hold_d%0d", c), 32'(D), 32'h5);
         check($sformatf("hold_ready%0d", c), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      seen = 0;
      for (int c = 0; c < NSEG + 3; c++) begin
         tick();
         if (out_valid) seen++;
      end
      check("no_ghost_op", 32'(seen), 32'd0);

      // Reset in the 3rd BUSY cycle discards the operation
      A = 17'h00005; B = 17'h00003; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_d", 32'(D), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      #1 rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < NSEG + 3; c++) begin
         tick();
         if (out_valid) seen++;
      end
      check("midrst_no_valid", 32'(seen), 32'd0);
      v = '{17'h1ABCD, 17'h0BCDE, 1'b0, 18'h0EEEF};
      run_op("after_rst", v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
